// File: rtl/ldl_rr_dispatch.sv
// Round-robin dispatcher: fans one valid/ready stream out to REQ_WIDTH sinks in rotating order.
// Optional one-entry input skid register enabled by defining LDL_RR_DISPATCH_SKID_EN.
module ldl_rr_dispatch #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_WIDTH-1:0]  sink_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [REQ_WIDTH-1:0]  out_valid,
  input  logic [REQ_WIDTH-1:0]  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [BIN_WIDTH-1:0]  out_bin
);

  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [BIN_WIDTH-1:0]  out_bin_q, out_bin_d;
  logic [BIN_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  sel_ok;
  logic                  drain;
  logic                  load;
  logic                  accept;
  logic                  src_vld;
  logic [DATA_WIDTH-1:0] src_data;
  logic [BIN_WIDTH-1:0]  nxt, nxt_hi, nxt_lo;
  logic                  have_hi;

  assign sel_ok = |sink_en;
  assign drain  = hold_vld_q & out_ready[out_bin_q];
  assign accept = in_valid & in_ready;

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    nxt_hi  = '0;
    nxt_lo  = '0;
    have_hi = 1'b0;
    for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
      if (sink_en[i]) begin
        nxt_lo = BIN_WIDTH'(i);
        if (i > int'(ptr_q)) begin
          nxt_hi  = BIN_WIDTH'(i);
          have_hi = 1'b1;
        end
      end
    end
    nxt = have_hi ? nxt_hi : nxt_lo;
  end

`ifdef LDL_RR_DISPATCH_SKID_EN
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  // Ready depends only on skid occupancy, cutting the path from out_ready/sink_en.
  assign in_ready = ~skid_vld_q & ~rst;
  assign src_vld  = skid_vld_q | accept;
  assign src_data = skid_vld_q ? skid_data_q : in_data;

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (skid_vld_q) begin
      if (load) begin
        skid_vld_d = accept;
        if (accept) begin
          skid_data_d = in_data;
        end
      end
    end else if (accept && !load) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_ready = ~rst & sel_ok & (~hold_vld_q | out_ready[out_bin_q]);
  assign src_vld  = in_valid;
  assign src_data = in_data;
`endif

  assign load = sel_ok & (~hold_vld_q | drain) & src_vld;

  // Target is fixed at load time; later sink_en changes never retarget a held item.
  always_comb begin
    hold_vld_d = hold_vld_q;
    out_data_d = out_data_q;
    out_bin_d  = out_bin_q;
    ptr_d      = ptr_q;
    if (load) begin
      hold_vld_d = 1'b1;
      out_data_d = src_data;
      out_bin_d  = nxt;
      ptr_d      = nxt;
    end else if (drain) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      out_data_q <= '0;
      out_bin_q  <= '0;
      ptr_q      <= BIN_WIDTH'(REQ_WIDTH - 1);
    end else begin
      hold_vld_q <= hold_vld_d;
      out_data_q <= out_data_d;
      out_bin_q  <= out_bin_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = hold_vld_q ? (REQ_WIDTH'(1) << out_bin_q) : '0;
  assign out_data  = out_data_q;
  assign out_bin   = out_bin_q;

endmodule

// File: tb/tb_ldl_rr_dispatch.sv
// Self-checking bench for ldl_rr_dispatch: directed phases plus randomized traffic vs a queue model.
// Follows LDL_RR_DISPATCH_SKID_EN in step with the design build.
module tb_ldl_rr_dispatch;
  localparam int BW = 2;
  localparam int RW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [RW-1:0] sink_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] out_valid;
  logic [RW-1:0] out_ready;
  logic [DW-1:0] out_data;
  logic [BW-1:0] out_bin;

  ldl_rr_dispatch #(.BIN_WIDTH(BW), .REQ_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .sink_en(sink_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bin(out_bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: pend holds every accepted, undelivered item in order; pend[0] is in the
  // output register when m_hold is set, anything else is waiting in the skid.
  logic [DW-1:0] pend[$];
  bit            m_hold = 1'b0;
  int            m_bin  = 0;
  int            m_ptr  = RW - 1;
  logic [DW-1:0] m_data = '0;
  int            log_bins[$];
  logic [DW-1:0] last_del = '0;
  bit            exp_rdy;

  function automatic int next_target(int p, logic [RW-1:0] en);
    for (int j = 1; j <= RW; j++) begin
      int idx = (p + j) % RW;
      if (en[idx]) return idx;
    end
    return p;
  endfunction

  always @(negedge clk) begin
    logic [RW-1:0] exp_ov;
    bit acc, drn, can;
    #2;
    exp_ov = m_hold ? (RW'(1) << m_bin) : '0;
`ifdef LDL_RR_DISPATCH_SKID_EN
    exp_rdy = !rst && (pend.size() == (m_hold ? 1 : 0));
`else
    exp_rdy = !rst && (|sink_en) && (!m_hold || out_ready[m_bin]);
`endif
    chk("out_valid", out_valid, exp_ov);
    chk("out_bin", out_bin, m_bin);
    chk("out_data", out_data, m_data);
    chk("in_ready", in_ready, exp_rdy);
    if (rst) begin
      pend.delete();
      m_hold = 1'b0;
      m_bin  = 0;
      m_ptr  = RW - 1;
      m_data = '0;
    end else begin
      acc = in_valid && exp_rdy;
      drn = m_hold && out_ready[m_bin];
      can = (|sink_en) && (!m_hold || drn);
      if (drn) begin
        log_bins.push_back(m_bin);
        chk("deliver_order", out_data > last_del, 1);
        last_del = out_data;
        void'(pend.pop_front());
        m_hold = 1'b0;
      end
      if (acc) pend.push_back(in_data);
      if (can && pend.size() > 0) begin
        m_bin  = next_target(m_ptr, sink_en);
        m_ptr  = m_bin;
        m_data = pend[0];
        m_hold = 1'b1;
      end
    end
  end

  logic [DW-1:0] dcnt = 1;

  task automatic drv(bit r, logic [RW-1:0] en, bit iv, logic [RW-1:0] ordy);
    @(negedge clk);
    rst       = r;
    sink_en   = en;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = dcnt;
    dcnt++;
  endtask

  task automatic chk_log(string nm, int e[$]);
    chk({nm, "_len"}, log_bins.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < log_bins.size()) chk(nm, log_bins[i], e[i]);
  endtask

  initial begin
    int e[$];
    rst = 1'b1; sink_en = '1; in_valid = 1'b0; out_ready = '1; in_data = '0;

    drv(1, 4'hF, 0, 4'hF); #3 chk("rst_in_ready", in_ready, 0);
    repeat (2) drv(1, 4'hF, 0, 4'hF);
    drv(0, 4'hF, 0, 4'hF); #3 chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);

    // all sinks enabled and ready, back-to-back
    log_bins.delete();
    drv(0, 4'hF, 1, 4'hF);
    drv(0, 4'hF, 1, 4'hF); #3 chk("first_latency", out_valid, 4'b0001);
    repeat (6) drv(0, 4'hF, 1, 4'hF);
    repeat (3) drv(0, 4'hF, 0, 4'hF);
    #3 e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_log("rr_all", e);

    // only sinks 1 and 3 enabled
    log_bins.delete();
    for (int i = 0; i < 8; i++) begin
      drv(0, 4'b1010, 1, 4'hF); #3 chk("sink02_idle", out_valid & 4'b0101, 0);
    end
    repeat (3) drv(0, 4'b1010, 0, 4'hF);
    #3 e = '{1, 3, 1, 3, 1, 3, 1, 3}; chk_log("rr_1010", e);

    // sink 2 stalls
    log_bins.delete();
    repeat (8) drv(0, 4'hF, 1, 4'b1011);
    #3 chk("stall_valid", out_valid, 4'b0100);
    chk("stall_bin", out_bin, 2);
    chk("stall_in_ready", in_ready, 0);
    drv(0, 4'hF, 1, 4'hF);
    repeat (3) drv(0, 4'hF, 0, 4'hF);
    #3 e = '{0, 1, 2, 3}; chk_log("stall_seq", e);

    // retarget attempt while holding for sink 1
    repeat (2) drv(1, 4'hF, 0, 4'hF);
    log_bins.delete();
    drv(0, 4'hF, 1, 4'b1101);
    drv(0, 4'hF, 1, 4'b1101);
    repeat (3) drv(0, 4'b0001, 1, 4'b1101);
    #3 chk("held_bin", out_bin, 1);
    chk("held_valid", out_valid, 4'b0010);
    drv(0, 4'b0001, 1, 4'hF);
    drv(0, 4'b0000, 1, 4'hF);
`ifndef LDL_RR_DISPATCH_SKID_EN
    #3 chk("en0_in_ready", in_ready, 0);
`endif
    repeat (2) drv(0, 4'b0000, 0, 4'hF);
    #3 e = '{0, 1, 0}; chk_log("commit_seq", e);

    // reset with everything full
    repeat (3) drv(0, 4'hF, 1, 4'h0);
    drv(1, 4'hF, 1, 4'h0);
    drv(0, 4'hF, 0, 4'hF); #3 chk("midrst_valid", out_valid, 0);
    chk("midrst_bin", out_bin, 0);
    log_bins.delete();
    drv(0, 4'hF, 1, 4'hF);
    repeat (2) drv(0, 4'hF, 0, 4'hF);
    #3 e = '{0}; chk_log("midrst_first", e);

    // randomized traffic
    begin
      logic [RW-1:0] en;
      en = 4'hF;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(15) == 0) en = RW'($urandom_range(15));
        drv(0, en, bit'($urandom_range(1)), RW'($urandom_range(15)));
`ifdef LDL_RR_DISPATCH_SKID_EN
        #3 out_ready = ~out_ready;
        #1 chk("rdy_indep", in_ready, exp_rdy);
        out_ready = ~out_ready;
`endif
      end
      repeat (4) drv(0, 4'hF, 0, 4'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
